// File: rtl/ula_pkg.sv
// Shared opcodes, FSM encoding and display constants for the arbitrated ALU.
package ula_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_DBL  = 3'b100;
  localparam logic [2:0] OP_HALF = 3'b101;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

endpackage

// File: rtl/decodificador_7seg.sv
// Hex digit to active-low 7-segment pattern (bit 6 = a ... bit 0 = g); 10..15 blank.
module decodificador_7seg
  import ula_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digito)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ula_arbitro.sv
// Two-requester round-robin arbiter in front of a small ALU, three cycles per
// operation (capture, compute, deliver), with a 7-segment view of the last good result.
module ula_arbitro
  import ula_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [2:0]   sel0,
  input  logic [2:0]   sel1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] resultado,
  output logic         erro,
  output logic         ocupado,
  output logic [6:0]   HEX2
);

  estado_t        estado, prox;
  logic           ptr;
  logic           dono;
  logic           vencedor;
  logic [2:0]     sel_p0;
  logic [W-1:0]   a_p0, b_p0;
  logic [W-1:0]   alu_res;
  logic           alu_err;
  logic [3:0]     disp;

  // MSB flags an illegal opcode; the result is forced to zero in that case.
  function automatic logic [W:0] ula_calc(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    case (op)
      OP_AND:  r[W-1:0] = a & b;
      OP_OR:   r[W-1:0] = a | b;
      OP_ADD:  r[W-1:0] = a + b;
      OP_SUB:  r[W-1:0] = a - b;
      OP_DBL:  r[W-1:0] = a << 1;
      OP_HALF: r[W-1:0] = a >> 1;
      default: r[W]     = 1'b1;
    endcase
    return r;
  endfunction

  // With both requests pending the pointer decides; otherwise the lone requester wins.
  assign vencedor = (req0 & req1) ? ptr : ~req0;

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (req0 | req1) prox = CALCULA;
      CALCULA: prox = ENTREGA;
      ENTREGA: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= OCIOSO;
      ptr       <= 1'b0;
      dono      <= 1'b0;
      resultado <= '0;
      erro      <= 1'b0;
      done_id   <= 1'b0;
      disp      <= 4'd0;
    end else begin
      estado <= prox;
      if (estado == OCIOSO && (req0 | req1)) begin
        dono <= vencedor;
        ptr  <= ~vencedor;
      end
      if (estado == CALCULA) begin
        resultado <= alu_res;
        erro      <= alu_err;
        done_id   <= dono;
      end
      if (estado == ENTREGA && !erro) disp <= resultado[3:0];
    end
  end

  // Operand capture stage: only the values latched on the grant edge are used.
  always_ff @(posedge clk) begin
    if (estado == OCIOSO) begin
      sel_p0 <= vencedor ? sel1 : sel0;
      a_p0   <= vencedor ? a1 : a0;
      b_p0   <= vencedor ? b1 : b0;
    end
  end

  assign {alu_err, alu_res} = ula_calc(sel_p0, a_p0, b_p0);

  assign gnt0    = (estado == CALCULA) && !dono;
  assign gnt1    = (estado == CALCULA) &&  dono;
  assign done    = (estado == ENTREGA);
  assign ocupado = (estado != OCIOSO);

  decodificador_7seg u_dec (
    .digito (disp),
    .seg    (HEX2)
  );

endmodule

// File: tb/tb_ula_arbitro.sv
// Bench for ula_arbitro: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ula_arbitro;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] sel0 = 3'd0, sel1 = 3'd0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic       gnt0, gnt1, done, done_id, erro, ocupado;
  logic [3:0] resultado;
  logic [6:0] HEX2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ula_arbitro #(.W(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .sel0(sel0), .sel1(sel1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .done_id(done_id),
    .resultado(resultado), .erro(erro), .ocupado(ocupado), .HEX2(HEX2)
  );

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'h7F, 7'h7F,
                               7'h7F, 7'h7F, 7'h7F, 7'h7F};

  // Model: m_cnt = cycles since the grant (0 idle, 1 grant cycle, 2 done cycle).
  int m_cnt = 0, m_ptr = 0, m_owner = 0, m_id = 0;
  int m_res = 0, m_err = 0, m_disp = 0, p_res = 0, p_err = 0;

  function automatic void m_alu(input int op, input int a, input int b,
                                output int r, output int e);
    e = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = (a + b) % 16;
      3: r = (a - b + 16) % 16;
      4: r = (a * 2) % 16;
      5: r = a / 2;
      default: begin r = 0; e = 1; end
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_res = 0; m_err = 0; m_id = 0; m_disp = 0;
    end else if (m_cnt == 2) begin
      if (m_err == 0) m_disp = m_res;
      m_cnt = 0;
    end else if (m_cnt == 1) begin
      m_res = p_res; m_err = p_err; m_id = m_owner; m_cnt = 2;
    end else if (req0 || req1) begin
      m_owner = (req0 && req1) ? m_ptr : (req0 ? 0 : 1);
      m_ptr   = 1 - m_owner;
      if (m_owner == 0) m_alu(int'(sel0), int'(a0), int'(b0), p_res, p_err);
      else              m_alu(int'(sel1), int'(a1), int'(b1), p_res, p_err);
      m_cnt = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("gnt0", 32'(gnt0), 32'(m_cnt == 1 && m_owner == 0));
    chk("gnt1", 32'(gnt1), 32'(m_cnt == 1 && m_owner == 1));
    chk("done", 32'(done), 32'(m_cnt == 2));
    chk("ocupado", 32'(ocupado), 32'(m_cnt != 0));
    chk("resultado", 32'(resultado), 32'(m_res));
    chk("HEX2", 32'(HEX2), 32'(seg_tab[m_disp]));
    if (m_cnt == 2) begin
      chk("done_id", 32'(done_id), 32'(m_id));
      chk("erro", 32'(erro), 32'(m_err));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Single-requester operation: grant, done (result captured), then display.
  task automatic run_op(input int r, input logic [2:0] s, input logic [3:0] a,
                        input logic [3:0] b, output logic [3:0] res,
                        output logic e, output logic [6:0] hex);
    if (r == 0) begin req0 = 1'b1; sel0 = s; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; sel1 = s; a1 = a; b1 = b; end
    step();
    chk("op_gnt", 32'(r == 0 ? gnt0 : gnt1), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("op_done", 32'(done), 32'd1);
    res = resultado; e = erro;
    step();
    hex = HEX2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] res;
    logic       e;
    logic [6:0] hex;

    rst = 1'b1;
    step();
    step();
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resultado", 32'(resultado), 32'd0);
    chk("rst_hex", 32'(HEX2), 32'(7'b0000001));
    rst = 1'b0;

    // 4 + 3 from requester 0
    req0 = 1'b1; sel0 = 3'b010; a0 = 4'd4; b0 = 4'd3;
    step();
    chk("add_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    step();
    chk("add_done", 32'(done), 32'd1);
    chk("add_res", 32'(resultado), 32'd7);
    chk("add_id", 32'(done_id), 32'd0);
    step();
    chk("add_hex", 32'(HEX2), 32'(7'b0001111));

    run_op(1, 3'b011, 4'd3, 4'd5, res, e, hex);
    chk("sub_res", 32'(res), 32'd14);
    chk("sub_hex", 32'(hex), 32'(7'b1111111));

    run_op(0, 3'b010, 4'd9, 4'd9, res, e, hex);
    chk("wrap_add", 32'(res), 32'd2);
    run_op(0, 3'b100, 4'd12, 4'd7, res, e, hex);
    chk("dbl", 32'(res), 32'd8);
    run_op(0, 3'b101, 4'd7, 4'd2, res, e, hex);
    chk("half", 32'(res), 32'd3);

    run_op(0, 3'b010, 4'd2, 4'd3, res, e, hex);
    chk("five_res", 32'(res), 32'd5);
    chk("five_hex", 32'(hex), 32'(7'b0100100));
    run_op(0, 3'b110, 4'd2, 4'd3, res, e, hex);
    chk("ill_erro", 32'(e), 32'd1);
    chk("ill_res", 32'(res), 32'd0);
    chk("ill_hex", 32'(hex), 32'(7'b0100100));

    // Reset in the compute cycle aborts the operation and restores priority to 0
    req0 = 1'b1; sel0 = 3'b010; a0 = 4'd1; b0 = 4'd1;
    step();
    chk("abort_gnt0", 32'(gnt0), 32'd1);
    rst = 1'b1; req0 = 1'b0;
    step();
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hex", 32'(HEX2), 32'(7'b0000001));
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    step();
    chk("rr_first", 32'(gnt0), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i % 3 == 0) begin
        chk("rr_alt_gnt1", 32'(gnt1), 32'((i / 3) % 2));
        chk("rr_alt_gnt0", 32'(gnt0), 32'(1 - (i / 3) % 2));
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 10 && ocupado; k++) step();
    chk("idle_wait", 32'(ocupado), 32'd0);

    // Request raised while busy is served right after returning to idle
    req0 = 1'b1; sel0 = 3'b000; a0 = 4'hF; b0 = 4'd3;
    step();
    req0 = 1'b0; req1 = 1'b1; sel1 = 3'b001; a1 = 4'd4; b1 = 4'd1;
    step();
    step();
    chk("pend_idle_gnt1", 32'(gnt1), 32'd0);
    chk("pend_idle_ocup", 32'(ocupado), 32'd0);
    step();
    chk("pend_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    step();
    chk("pend_res", 32'(resultado), 32'd5);
    step();

    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      req0 = ($urandom_range(0, 9) < 6);
      req1 = ($urandom_range(0, 9) < 6);
      sel0 = 3'($urandom_range(0, 7));
      sel1 = 3'($urandom_range(0, 7));
      a0 = 4'($urandom_range(0, 15));
      b0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      b1 = 4'($urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_arbitro.md
ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 Parameter W, default 4, operand and result width in bits; only W=4 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0 / req1  input  1 each  requester 0/1 operation request, level, held until the matching gnt.
REQ-005 sel0 / sel1  input  3 each  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 A*2, 101 A/2, 110/111 illegal.
REQ-006 a0, b0 / a1, b1  input  W each  operands of requester 0/1.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle pulse: that requester's operands are captured.
REQ-008 done  output  1  one-cycle pulse: resultado is valid.
REQ-009 done_id  output  1  requester owning the current result, valid when done=1.
REQ-010 resultado  output  W  registered ALU result.
REQ-011 erro  output  1  high with done when the opcode was illegal.
REQ-012 ocupado  output  1  high whenever the FSM is not in OCIOSO.
REQ-013 HEX2  output  7  active-low 7-segment pattern (bit 6 = a ... bit 0 = g) of the last delivered result.

Function
REQ-014 FSM states: OCIOSO, CALCULA, ENTREGA; transitions OCIOSO->CALCULA when req0|req1, CALCULA->ENTREGA always, ENTREGA->OCIOSO always.
REQ-015 On the OCIOSO->CALCULA edge: winner's sel/a/b are registered, gnt of the winner is high for exactly the CALCULA cycle.
REQ-016 Arbitration is round-robin: with both req high, the grant goes to the requester not served last; with a single req, that requester wins regardless of pointer.
REQ-017 Pointer updates only on a grant; after reset requester 0 has priority.
REQ-018 On the CALCULA->ENTREGA edge: resultado, erro and done_id are registered; done is high for exactly the ENTREGA cycle.
REQ-019 Latency: request sampled at edge N -> gnt in cycle N+1 -> done in cycle N+2; a new grant is possible at edge N+3 at the earliest (3 cycles per operation).
REQ-020 Arithmetic is modulo 2^W: ADD 9+9=2, SUB 3-5=14, A*2 of 12 = 8 (b ignored), A/2 floors (7->3, b ignored).
REQ-021 Illegal opcode: resultado=0, erro=1; display register is not updated.
REQ-022 Display register loads resultado on each legal done; HEX2 decodes 0..9 to standard digits (0 -> 0000001, 1 -> 1001111, 2 -> 0010010, 3 -> 0000110, 4 -> 1001100, 5 -> 0100100, 6 -> 0100000, 7 -> 0001111, 8 -> 0000000, 9 -> 0000100) and 10..15 to blank 1111111.
REQ-023 Requests arriving while ocupado=1 are not lost: they remain pending (level) and are arbitrated at the next OCIOSO cycle.
REQ-024 A requester dropping req before its gnt is simply not served; no partial state remains.

Reset
REQ-025 rst sampled high at an edge forces OCIOSO, priority pointer to requester 0, gnt0=gnt1=done=erro=done_id=ocupado=0, resultado=0, display register=0 (HEX2=0000001).
REQ-026 rst high in CALCULA or ENTREGA aborts the operation: no done pulse, no display update.
REQ-027 rst has priority over every other event in the same cycle.

Structure
REQ-028 Opcode constants, FSM state encodings and the blank-pattern constant live in a shared package ula_pkg.
REQ-029 The 7-segment decoding is one sub-module, decodificador_7seg (4-bit in, 7-bit active-low out); the ALU is combinational logic inside ula_arbitro.

Verification
REQ-030 Reset then req0 only, sel0=010, a0=4, b0=3 -> gnt0 in cycle 1, done in cycle 2 with resultado=7, done_id=0, then HEX2=0001111.
REQ-031 req0 and req1 both held continuously -> grants alternate 0,1,0,1 every 3 cycles.
REQ-032 req1 only with sel1=011, a1=3, b1=5 -> resultado=14, HEX2=1111111.
REQ-033 sel0=110 after a legal result of 5 -> done with erro=1, resultado=0, HEX2 stays 0100100.
REQ-034 rst pulsed during CALCULA -> no done, ocupado=0 next cycle, HEX2=0000001, next grant to requester 0.
REQ-035 req1 raised while ocupado serving req0 -> gnt1 in the cycle after returning to OCIOSO, no request lost.
